qeciphy_pchannel_responder: RTL and testbench

- P-channel responder for the QECIPHY power/link interface. It is the device end of the PREQ/PSTATE/PACCEPT/PACTIVE handshake that a controller (VIO or system logic) initiates.
- Sequences link bring-up and teardown through link_en and waits on link status before accepting a request.
- Drives PACTIVE as a wake hint.
- Flags timeouts and protocol violations for the STATUS/ECODE path.

---
 rtl/qeciphy_pchannel_responder.sv | 154 +++++++++++++++
 tb/tb_qeciphy_pchannel_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_pchannel_responder.sv
// Device-side P-channel responder: answers PREQ/PSTATE with PACCEPT, sequences the link
// through link_en, drives PACTIVE as a wake hint and records sticky timeout/protocol errors.
module qeciphy_pchannel_responder #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic ACLK,
    input  logic ARSTn,
    input  logic PREQ,
    input  logic PSTATE,
    output logic PACCEPT,
    output logic PACTIVE,
    output logic link_en,
    input  logic link_up,
    input  logic tx_idle,
    input  logic wake_req,
    output logic cur_state,
    output logic timeout_err,
    output logic proto_err
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ON_UP,
        ST_ON,
        ST_DRAIN,
        ST_DOWN,
        ST_ACCEPT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preq_q;
    logic             rise_q, rise_d;
    logic             tgt_q, tgt_d;
    logic             paccept_q, paccept_d;
    logic             link_en_q, link_en_d;
    logic             cur_state_q, cur_state_d;
    logic             timeout_err_q, timeout_err_d;
    logic             proto_err_q, proto_err_d;
    logic             pactive_q;
    logic             idle_st;
    logic             in_transition;
    logic             cnt_done;

    assign idle_st       = (state_q == ST_OFF) || (state_q == ST_ON);
    assign in_transition = (state_q == ST_ON_UP) || (state_q == ST_DRAIN) || (state_q == ST_DOWN);
    assign cnt_done      = (cnt_q >= CNT_LAST);

    // A PREQ rise is only meaningful from a stable state; rises during a
    // transition or while accepting are ignored and never disturb the target.
    assign rise_d = PREQ & ~preq_q & idle_st;
    assign tgt_d  = rise_d ? PSTATE : tgt_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        proto_err_d   = proto_err_q;
        unique case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (rise_q) state_d = tgt_q ? ST_ON_UP : ST_ACCEPT;
            end
            ST_ON: begin
                cnt_d = '0;
                if (rise_q) state_d = tgt_q ? ST_ACCEPT : ST_DRAIN;
            end
            ST_ON_UP: begin
                if (link_up) begin
                    state_d = ST_ACCEPT;
                end else if (cnt_done) begin
                    state_d       = ST_ACCEPT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Timeout wins here: moving to DOWN would not complete the request.
                if (cnt_done) begin
                    state_d       = ST_ACCEPT;
                    timeout_err_d = 1'b1;
                end else if (tx_idle) begin
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (!link_up) begin
                    state_d = ST_ACCEPT;
                end else if (cnt_done) begin
                    state_d       = ST_ACCEPT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_ACCEPT: begin
                cnt_d = '0;
                if (!PREQ) state_d = tgt_q ? ST_ON : ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // The counter spans the whole transition (DRAIN into DOWN) and saturates.
        if (in_transition) begin
            if (!PREQ) proto_err_d = 1'b1;
            if (state_d == ST_ACCEPT)  cnt_d = '0;
            else if (cnt_q != '1)      cnt_d = cnt_q + CNT_W'(1);
        end

        paccept_d   = (state_d == ST_ACCEPT);
        link_en_d   = (state_d == ST_ON_UP) || (state_d == ST_ON) || (state_d == ST_DRAIN) ||
                      ((state_d == ST_ACCEPT) && tgt_q);
        cur_state_d = (state_d == ST_ACCEPT) ? tgt_q : cur_state_q;
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q       <= ST_OFF;
            cnt_q         <= '0;
            preq_q        <= 1'b0;
            rise_q        <= 1'b0;
            tgt_q         <= 1'b0;
            paccept_q     <= 1'b0;
            link_en_q     <= 1'b0;
            cur_state_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
            pactive_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            preq_q        <= PREQ;
            rise_q        <= rise_d;
            tgt_q         <= tgt_d;
            paccept_q     <= paccept_d;
            link_en_q     <= link_en_d;
            cur_state_q   <= cur_state_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
            pactive_q     <= wake_req | link_up;
        end
    end

    assign PACCEPT     = paccept_q;
    assign PACTIVE     = pactive_q;
    assign link_en     = link_en_q;
    assign cur_state   = cur_state_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_qeciphy_pchannel_responder.sv
// Bench for qeciphy_pchannel_responder: directed request table, reset sequence, then
// random requests predicted by a transaction-level latency model.
module tb_qeciphy_pchannel_responder;

    localparam int T       = 16;
    localparam int CW      = 5;
    localparam int TO_EDGE = T + 2;   // sample index at which a timed-out request is accepted

    logic ACLK = 1'b0;
    logic ARSTn, PREQ, PSTATE, link_up, tx_idle, wake_req;
    logic PACCEPT, PACTIVE, link_en, cur_state, timeout_err, proto_err;

    int errors = 0;
    int checks = 0;
    bit act_prev;
    bit chk_act;
    bit cur_model;
    bit err_to, err_pe;

    typedef struct {
        bit tgt;
        int d_up;
        int i_idle;
        int d_dn;
        int drop_at;
        int exp_acc;
        bit exp_to;
        bit exp_pe;
    } vec_t;

    vec_t tbl[12];

    always #5 ACLK = ~ACLK;

    qeciphy_pchannel_responder #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARSTn(ARSTn), .PREQ(PREQ), .PSTATE(PSTATE),
        .PACCEPT(PACCEPT), .PACTIVE(PACTIVE), .link_en(link_en),
        .link_up(link_up), .tx_idle(tx_idle), .wake_req(wake_req),
        .cur_state(cur_state), .timeout_err(timeout_err), .proto_err(proto_err)
    );

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // One clock; PACTIVE must reflect wake_req|link_up as driven before the edge.
    task automatic step();
        act_prev = wake_req | link_up;
        @(posedge ACLK);
        #1;
        if (chk_act) check("PACTIVE", PACTIVE, act_prev);
        wake_req = 1'($urandom_range(0, 1));
    endtask

    // Sample index (after PREQ is driven) at which PACCEPT is first seen, from the
    // handshake rules: one edge to detect the rise, one to leave the stable state,
    // then T counted cycles in the transition before it is forced.
    function automatic void predict(input bit from_st, input bit tgt, input int d_up,
                                    input int i_idle, input int d_dn,
                                    output int acc, output bit tmo);
        int c;
        if (from_st == tgt) begin
            acc = 2;
            tmo = 1'b0;
        end else if (tgt) begin
            acc = 3 + ((d_up < T) ? d_up : T - 1);
            tmo = (d_up > T - 1);
        end else begin
            c   = 4 + i_idle + d_dn;
            acc = (c < TO_EDGE) ? c : TO_EDGE;
            tmo = (c > TO_EDGE);
        end
    endfunction

    task automatic run_txn(input int id, input bit tgt, input int d_up, input int i_idle,
                           input int d_dn, input int drop_at, input int exp_acc,
                           input bit exp_to, input bit exp_pe);
        bit from_st;
        bit exp_le;
        int le_end;
        from_st = cur_model;
        le_end  = ((3 + i_idle) < exp_acc) ? (3 + i_idle) : exp_acc;
        PREQ    = 1'b1;
        PSTATE  = tgt;
        if (from_st && !tgt) tx_idle = 1'b0;
        for (int j = 1; j <= exp_acc; j++) begin
            step();
            if (from_st == tgt) exp_le = tgt;
            else if (tgt)       exp_le = (j >= 2);
            else                exp_le = (j < le_end);
            check("link_en", link_en, exp_le);
            check("PACCEPT", PACCEPT, logic'(j == exp_acc));
            if (from_st != tgt && tgt && j == 2 + d_up) link_up = 1'b1;
            if (from_st != tgt && !tgt && j == 2 + i_idle) tx_idle = 1'b1;
            if (from_st != tgt && !tgt && j == 3 + i_idle + d_dn) link_up = 1'b0;
            if (j == drop_at) PREQ = 1'b0;
            if (PREQ) PSTATE = 1'($urandom_range(0, 1));
        end
        check("timeout_err", timeout_err, exp_to);
        check("proto_err", proto_err, exp_pe);
        PREQ = 1'b0;
        step();
        check("PACCEPT_drop", PACCEPT, 1'b0);
        check("cur_state", cur_state, tgt);
        check("link_en_final", link_en, tgt);
        cur_model = tgt;
        link_up   = tgt;
        tx_idle   = 1'b1;
        $display("txn %0d: %0d->%0d accept@%0d drop@%0d tmo=%0d perr=%0d errors=%0d",
                 id, from_st, tgt, exp_acc, drop_at, exp_to, exp_pe, errors);
    endtask

    int  acc, r_up, r_idle, r_dn, r_drop;
    bit  tmo, r_tgt;

    initial begin
        chk_act   = 1'b0;
        cur_model = 1'b0;
        err_to    = 1'b0;
        err_pe    = 1'b0;
        ARSTn     = 1'b0;
        PREQ      = 1'b0;
        PSTATE    = 1'b0;
        link_up   = 1'b0;
        tx_idle   = 1'b1;
        wake_req  = 1'b0;

        //          tgt d_up idle dn drop acc to pe
        tbl[0]  = '{1, 10,  0, 0, 0, 13, 0, 0};
        tbl[1]  = '{0,  0,  5, 3, 0, 12, 0, 0};
        tbl[2]  = '{0,  0,  0, 0, 0,  2, 0, 0};
        tbl[3]  = '{1,  0,  0, 0, 0,  3, 0, 0};
        tbl[4]  = '{1,  0,  0, 0, 0,  2, 0, 0};
        tbl[5]  = '{0,  0,  0, 1, 0,  5, 0, 0};
        tbl[6]  = '{1, 15,  0, 0, 0, 18, 0, 0};
        tbl[7]  = '{0,  0, 14, 1, 0, 18, 1, 0};
        tbl[8]  = '{1, 99,  0, 0, 0, 18, 1, 0};
        tbl[9]  = '{0,  0,  2, 2, 4,  8, 1, 1};
        tbl[10] = '{1,  3,  0, 0, 2,  6, 1, 1};
        tbl[11] = '{0,  0,  1, 1, 0,  6, 1, 1};

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_PACCEPT", PACCEPT, 1'b0);
        check("rst_link_en", link_en, 1'b0);
        check("rst_cur_state", cur_state, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_PACTIVE", PACTIVE, 1'b0);
        ARSTn = 1'b1;
        step();
        check("idle_link_en", link_en, 1'b0);
        check("idle_PACCEPT", PACCEPT, 1'b0);
        chk_act = 1'b1;

        for (int i = 0; i < 12; i++)
            run_txn(i, tbl[i].tgt, tbl[i].d_up, tbl[i].i_idle, tbl[i].d_dn, tbl[i].drop_at,
                    tbl[i].exp_acc, tbl[i].exp_to, tbl[i].exp_pe);

        // Reset in the middle of a link bring-up, with a wake request pending.
        PREQ   = 1'b1;
        PSTATE = 1'b1;
        repeat (4) step();
        check("onup_link_en", link_en, 1'b1);
        wake_req = 1'b1;
        chk_act  = 1'b0;
        #2 ARSTn = 1'b0;
        #1;
        check("arst_link_en", link_en, 1'b0);
        check("arst_PACCEPT", PACCEPT, 1'b0);
        check("arst_cur_state", cur_state, 1'b0);
        check("arst_timeout_err", timeout_err, 1'b0);
        check("arst_proto_err", proto_err, 1'b0);
        check("arst_PACTIVE", PACTIVE, 1'b0);
        PREQ = 1'b0;
        @(posedge ACLK);
        #1;
        check("arst_hold_PACTIVE", PACTIVE, 1'b0);
        ARSTn = 1'b1;
        @(posedge ACLK);
        #1;
        check("rel_PACTIVE", PACTIVE, 1'b1);
        check("rel_link_en", link_en, 1'b0);
        cur_model = 1'b0;
        err_to    = 1'b0;
        err_pe    = 1'b0;
        chk_act   = 1'b1;

        for (int n = 0; n < 40; n++) begin
            r_tgt  = 1'($urandom_range(0, 1));
            r_up   = int'($urandom_range(0, 20));
            r_idle = int'($urandom_range(0, 16));
            r_dn   = int'($urandom_range(0, 6));
            predict(cur_model, r_tgt, r_up, r_idle, r_dn, acc, tmo);
            r_drop = 0;
            if (cur_model != r_tgt && $urandom_range(0, 4) == 0)
                r_drop = int'($urandom_range(2, acc - 1));
            err_to = err_to | tmo;
            err_pe = err_pe | (r_drop != 0);
            run_txn(100 + n, r_tgt, r_up, r_idle, r_dn, r_drop, acc, err_to, err_pe);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
